// File: rtl/key_debounce.sv
// Push-button conditioning: synchronizes raw active-low keys, debounces them on a
// shared sample tick, and derives press/release strobes plus long-press auto-repeat.
`timescale 1ns/1ps
module key_debounce #(
  parameter int N_KEYS       = 3,
  parameter int TICK_LEN     = 50_000,
  parameter int STABLE_TICKS = 20,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic              CLK_50,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_hold,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int TICK_W   = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;
  localparam int DB_W     = $clog2(STABLE_TICKS + 1);
  localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DOWN,
    HELD
  } hold_state_e;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  // Reset value 1 makes every key read as released until proven otherwise.
  always_ff @(posedge CLK_50) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign tick = (tick_cnt_q == TICK_W'(TICK_LEN - 1));

  always_ff @(posedge CLK_50) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic              stable_q;
    logic              stable_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    hold_state_e       state_q;
    logic              down_q;
    logic              press_q;
    logic              release_q;
    logic              hold_q;
    logic              repeat_q;
    logic              press_acc;
    logic              release_acc;

    // Any sample agreeing with the accepted level restarts the count, so only a
    // level that disagrees on STABLE_TICKS consecutive ticks gets through.
    always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q[k] == stable_q) begin
        db_cnt_d = '0;
      end else if (tick) begin
        if (db_cnt_q == DB_W'(STABLE_TICKS - 1)) begin
          stable_d = sync2_q[k];
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    assign press_acc   = stable_q & ~stable_d;
    assign release_acc = ~stable_q & stable_d;

    always_ff @(posedge CLK_50) begin
      if (!rst_n) begin
        stable_q   <= 1'b1;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        state_q    <= IDLE;
        down_q     <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        down_q    <= ~stable_d;
        press_q   <= press_acc;
        release_q <= release_acc;
        repeat_q  <= 1'b0;
        case (state_q)
          IDLE: begin
            if (press_acc) begin
              state_q    <= DOWN;
              hold_cnt_q <= '0;
            end
          end
          DOWN: begin
            if (release_acc) begin
              state_q    <= IDLE;
              hold_cnt_q <= '0;
              hold_q     <= 1'b0;
            end else if (tick) begin
              if (hold_cnt_q == HOLD_W'(HOLD_TICKS - 1)) begin
                state_q    <= HELD;
                hold_q     <= 1'b1;
                repeat_q   <= 1'b1;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
          end
          HELD: begin
            // Release is checked first so it suppresses a coincident repeat.
            if (release_acc) begin
              state_q    <= IDLE;
              hold_cnt_q <= '0;
              hold_q     <= 1'b0;
            end else if (tick) begin
              if (hold_cnt_q == HOLD_W'(REPEAT_TICKS - 1)) begin
                repeat_q   <= 1'b1;
                hold_cnt_q <= '0;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
          end
        endcase
      end
    end

    assign key_down[k]    = down_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_hold[k]    = hold_q;
    assign key_repeat[k]  = repeat_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce using small timing parameters
// (TICK_LEN=4, STABLE_TICKS=3, HOLD_TICKS=10, REPEAT_TICKS=4).
`timescale 1ns/1ps
module tb_key_debounce;

  logic       CLK_50;
  logic       rst_n;
  logic [2:0] KEY;
  logic [2:0] key_down;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic [2:0] key_hold;
  logic [2:0] key_repeat;

  int compared;
  int mismatched;

  key_debounce #(
    .N_KEYS      (3),
    .TICK_LEN    (4),
    .STABLE_TICKS(3),
    .HOLD_TICKS  (10),
    .REPEAT_TICKS(4)
  ) dut (
    .CLK_50     (CLK_50),
    .rst_n      (rst_n),
    .KEY        (KEY),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold),
    .key_repeat (key_repeat)
  );

  initial CLK_50 = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge CLK_50);
    @(negedge CLK_50);
  endtask

  task automatic test_reset();
    int first;
    KEY   = 3'b000;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if ({key_down, key_press, key_release, key_hold, key_repeat} !== 15'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_outputs: got %b required 0",
                 {key_down, key_press, key_release, key_hold, key_repeat});
      end
    end
    rst_n = 1'b1;
    first = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      step();
      if (key_press !== 3'b000) begin
        first = n;
        compared++;
        if (key_press !== 3'b111 || key_down !== 3'b111) begin
          mismatched++;
          $display("[TB] FAIL reset_press_value: press %b down %b required 111/111", key_press, key_down);
        end
      end
    end
    compared++;
    if (first < 11 || first > 14) begin
      mismatched++;
      $display("[TB] FAIL reset_press_latency: got %0d cycles required 11..14", first);
    end
    KEY   = 3'b111;
    first = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      step();
      if (key_release !== 3'b000) first = n;
    end
    compared++;
    if (first == 0 || key_release !== 3'b111 || key_down !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_release: after %0d cycles release %b down %b required 111/000",
               first, key_release, key_down);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 60; i++) begin
      KEY[0] = (i < 40) ? (((i / 3) % 2) != 0) : 1'b1;
      step();
      compared++;
      if ({key_press[0], key_down[0]} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL bounce_reject: cycle %0d press/down %b required 00", i, {key_press[0], key_down[0]});
      end
    end
  endtask

  task automatic test_clean_press();
    int first;
    int pulses;
    int extra;
    KEY[1] = 1'b0;
    first  = 0;
    pulses = 0;
    extra  = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (key_press[1] === 1'b1) begin
        pulses++;
        if (first == 0) first = n;
      end
      if (key_hold[1] !== 1'b0 || key_repeat[1] !== 1'b0 || key_release[1] !== 1'b0) extra++;
    end
    compared++;
    if (pulses != 1 || first < 11 || first > 14) begin
      mismatched++;
      $display("[TB] FAIL clean_press: %0d pulses first at %0d required 1 pulse in 11..14", pulses, first);
    end
    compared++;
    if (key_down[1] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clean_down_level: got %b required 1", key_down[1]);
    end
    KEY[1] = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (key_release[1] === 1'b1) pulses++;
      if (key_hold[1] !== 1'b0 || key_repeat[1] !== 1'b0 || key_press[1] !== 1'b0) extra++;
    end
    compared++;
    if (pulses != 1 || key_down[1] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clean_release: %0d pulses down %b required 1 pulse down 0", pulses, key_down[1]);
    end
    compared++;
    if (extra != 0) begin
      mismatched++;
      $display("[TB] FAIL clean_spurious: %0d cycles with unexpected strobes required 0", extra);
    end
  endtask

  task automatic test_auto_repeat();
    int         first;
    logic [4:0] expected;
    logic [4:0] observed;
    KEY[2] = 1'b0;
    first  = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      step();
      if (key_press[2] === 1'b1) first = n;
    end
    compared++;
    if (first == 0) begin
      mismatched++;
      $display("[TB] FAIL repeat_press_timeout: no key_press[2] within 20 cycles");
      KEY[2] = 1'b1;
      return;
    end
    // Release is timed so the accepted release lands on the 4th repeat boundary (88).
    for (int n = 1; n <= 110; n++) begin
      step();
      expected = {n < 88, 1'b0, (n >= 40 && n < 88), (n == 40 || n == 56 || n == 72), n == 88};
      observed = {key_down[2], key_press[2], key_hold[2], key_repeat[2], key_release[2]};
      compared++;
      if (observed !== expected) begin
        mismatched++;
        $display("[TB] FAIL repeat_cycle_%0d: down/press/hold/repeat/release got %b required %b",
                 n, observed, expected);
      end
      if (n == 76) KEY[2] = 1'b1;
    end
  endtask

  task automatic test_independence();
    int first;
    int other;
    KEY   = 3'b010;
    first = 0;
    other = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      step();
      if (key_press[1] !== 1'b0 || key_down[1] !== 1'b0) other++;
      if (key_press !== 3'b000) begin
        first = n;
        compared++;
        if (key_press !== 3'b101) begin
          mismatched++;
          $display("[TB] FAIL indep_press: got %b required 101", key_press);
        end
      end
    end
    compared++;
    if (first == 0 || other != 0) begin
      mismatched++;
      $display("[TB] FAIL indep_timing: first %0d, key1 activity %0d required press seen, 0", first, other);
    end
  endtask

  task automatic test_midpress_reset();
    int first;
    int spurious;
    compared++;
    if (key_down !== 3'b101) begin
      mismatched++;
      $display("[TB] FAIL midreset_precondition: down %b required 101", key_down);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    compared++;
    if ({key_down, key_press, key_release, key_hold, key_repeat} !== 15'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got %b required 0",
               {key_down, key_press, key_release, key_hold, key_repeat});
    end
    first    = 0;
    spurious = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      step();
      if (key_release !== 3'b000) spurious++;
      if (key_press[0] === 1'b1) first = n;
    end
    compared++;
    if (first < 11 || first > 14 || spurious != 0) begin
      mismatched++;
      $display("[TB] FAIL midreset_repress: press at %0d releases %0d required 11..14 and 0", first, spurious);
    end
    KEY   = 3'b111;
    first = 0;
    for (int n = 1; n <= 20 && first == 0; n++) begin
      step();
      if (key_release !== 3'b000) first = n;
    end
    compared++;
    if (first == 0 || key_release !== 3'b101) begin
      mismatched++;
      $display("[TB] FAIL midreset_release: release %b after %0d required 101", key_release, first);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    KEY        = 3'b111;
    test_reset();
    test_bounce();
    test_clean_press();
    test_auto_repeat();
    test_independence();
    test_midpress_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side conditioning block for the board push-buttons: takes raw, bouncing, active-low KEY lines and produces clean active-high levels, single-cycle press/release strobes, and long-press auto-repeat strobes for downstream counter/control logic (en, load, step). It sits between the board pins and any CLK_50-domain logic that currently samples KEY directly. It contains a 2-flop synchronizer, a shared sample-tick divider and a per-key debounce and hold state machine.

## Interface
- N_KEYS, 3, number of independent key channels
- TICK_LEN, 50_000, CLK_50 cycles per sample tick (1 ms at 50 MHz)
- STABLE_TICKS, 20, consecutive mismatching ticks required to accept a new level
- HOLD_TICKS, 1000, ticks a key must stay down before hold and the first repeat
- REPEAT_TICKS, 200, ticks between subsequent repeat strobes while held
- CLK_50  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- KEY  in  N_KEYS  raw key inputs, active-low (0 = pressed), asynchronous to CLK_50
- key_down  out  N_KEYS  debounced level, 1 = pressed
- key_press  out  N_KEYS  one-cycle strobe on accepted press
- key_release  out  N_KEYS  one-cycle strobe on accepted release
- key_hold  out  N_KEYS  1 while a key has been down ≥ HOLD_TICKS
- key_repeat  out  N_KEYS  one-cycle auto-repeat strobe

## Operation
- Synchronizer: two flops per key, reset value 1 (released). All decisions use the second-stage value `s`.
- Tick divider: counter 0..TICK_LEN-1, wraps; `tick` is high for one cycle when the count equals TICK_LEN-1. Width is $clog2(TICK_LEN). One divider is shared by all keys.
- Per key, debounce state: `stable` (reset 1) and `db_cnt` (reset 0, width $clog2(STABLE_TICKS+1)).
  - If `s == stable`, then `db_cnt <= 0` on every cycle, whether or not a tick occurs.
  - If `s != stable` and `tick`:
    - when `db_cnt == STABLE_TICKS-1`, then `stable <= s` and `db_cnt <= 0`;
    - otherwise `db_cnt <= db_cnt+1`.
  - A single matching sample between ticks restarts the count. A glitch therefore never passes.
- key_down = ~stable, registered.
- key_press / key_release are asserted on the same edge that `stable` flips (1→0 and 0→1 respectively). They are high for exactly one CLK_50 cycle.
- Hold FSM per key, states IDLE, DOWN, HELD:
  - IDLE→DOWN on accepted press, with `hold_cnt <= 0`.
  - In DOWN, `hold_cnt` increments on each tick. When the tick arrives with `hold_cnt == HOLD_TICKS-1`, the FSM goes to HELD, sets key_hold=1, emits one key_repeat and sets `hold_cnt <= 0`.
  - In HELD, `hold_cnt` increments on each tick. When the tick arrives with `hold_cnt == REPEAT_TICKS-1`, the FSM emits key_repeat and sets `hold_cnt <= 0`.
  - DOWN or HELD → IDLE on accepted release. key_hold drops on the same edge as key_release, and `hold_cnt` clears.
  - If a release and a repeat boundary fall on the same tick, the release wins and no key_repeat is emitted.
- Keys are fully independent. Simultaneous presses on several keys produce simultaneous strobes.

## Timing
- Reset is synchronous. On the first CLK_50 edge with rst_n=0, the following take their reset values, and hold them while rst_n=0:
  - all outputs are 0;
  - synchronizers and `stable` are all 1;
  - all counters are 0;
  - the FSM is IDLE.
- Reset mid-press:
  - the key reads released after reset;
  - if KEY is still low, a fresh debounce is required, giving a new key_press after STABLE_TICKS ticks;
  - no key_release is emitted for the interrupted press.
- Press latency from a clean KEY edge:
  - 2 cycles of synchronizer delay;
  - then STABLE_TICKS ticks, the first counted tick being the next tick after `s` changes;
  - total between (STABLE_TICKS-1)·TICK_LEN+3 and STABLE_TICKS·TICK_LEN+2 cycles.
- key_down rises on the same cycle that key_press is high.
- First key_repeat arrives HOLD_TICKS ticks after key_press. Subsequent repeats are spaced exactly REPEAT_TICKS·TICK_LEN cycles apart.
- key_press and key_repeat can never be high in the same cycle on the same key.

## Test plan
Benches use TICK_LEN=4, STABLE_TICKS=3, HOLD_TICKS=10, REPEAT_TICKS=4, N_KEYS=3.
- Reset: hold rst_n=0 for 5 cycles with KEY=3'b000. All outputs must be 0. After release, key_press[2:0] rises no earlier than 11 and no later than 14 cycles later.
- Bounce rejection: toggle KEY[0] low/high every 3 cycles for 40 cycles, then leave it high. key_press[0] and key_down[0] must stay 0 throughout.
- Clean press/release: KEY[1] goes low at cycle 0. One key_press[1] pulse must occur within cycles 11–14, and key_down[1] stays 1. Then KEY[1] goes high. Exactly one key_release[1] pulse must occur, and key_down[1] falls.
- Auto-repeat: hold KEY[2] low. key_hold[2] and the first key_repeat[2] must appear exactly 40 cycles after key_press[2]. Further repeats follow every 16 cycles. On release, key_hold drops together with key_release, and no further repeats occur.
- Independence: press KEY[0] and KEY[2] on the same cycle. key_press[0] and key_press[2] must pulse on the same cycle, and key_press[1] stays 0.
- Mid-press reset: assert rst_n=0 for 1 cycle while key_down[0]=1. key_down[0] must go to 0 with no key_release. With KEY[0] still low, a new key_press[0] must follow within 14 cycles.
